// File: rtl/zc_pipe_chain_pkg.sv
// Shared widths, default depth and slot indices for the zerocore pipeline register chain.
package zc_pipe_chain_pkg;

  localparam int ADDR_BUS  = 64;
  localparam int INST_BUS  = 32;
  localparam int DATA_BUS  = ADDR_BUS + INST_BUS;
  localparam int ZC_STAGES = 4;

  localparam int SLOT_F2D = 0;
  localparam int SLOT_D2E = 1;
  localparam int SLOT_E2M = 2;
  localparam int SLOT_M2W = 3;

  typedef struct packed {
    logic [ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0] inst;
  } bundle_t;

endpackage

// File: rtl/zc_pipe_slot.sv
// One valid-tagged pipeline slot: flush clears the tag, load takes a new tag and
// captures the bundle only when that tag is set, so bubbles leave stale data in place.
module zc_pipe_slot
  import zc_pipe_chain_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              srcValid,
  input  logic [DATA_W-1:0] srcData,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // NOTE: state registers use non-blocking assignments so every slot samples its
  // neighbour's pre-edge value; the data register is reset too, as stage_data is observable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= srcValid;
      if (srcValid) data <= srcData;
    end
  end

endmodule

// File: rtl/zc_pipe_chain.sv
// In-order valid/ready pipeline register chain with per-slot stall and flush,
// bubble insertion and a 64-bit retire counter.
module zc_pipe_chain
  import zc_pipe_chain_pkg::*;
#(
  parameter int STAGES = ZC_STAGES,
  parameter int DATA_W = DATA_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [63:0]              retire_cnt
);

  logic [STAGES-1:0] slotValid;
  logic [DATA_W-1:0] slotData [STAGES];
  logic [STAGES:0]   take;
  logic [STAGES-1:0] srcValid;
  logic [DATA_W-1:0] srcData  [STAGES];
  logic [63:0]       retireCnt;

  // A slot can accept when not stalled and either empty or draining into the next one.
  always_comb begin
    take         = '0;
    take[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      take[i] = !stall[i] && (!slotValid[i] || take[i+1]);
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : gSlot
    if (g == 0) begin : gHead
      assign srcValid[g] = in_valid && !flush[g];
      assign srcData[g]  = in_data;
    end else begin : gBody
      assign srcValid[g] = slotValid[g-1] && !stall[g-1] && !flush[g-1];
      assign srcData[g]  = slotData[g-1];
    end

    zc_pipe_slot #(.DATA_W(DATA_W)) uSlot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .load     (take[g]),
      .srcValid (srcValid[g]),
      .srcData  (srcData[g]),
      .valid    (slotValid[g]),
      .data     (slotData[g])
    );

    assign stage_data[g*DATA_W +: DATA_W] = slotData[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retireCnt <= '0;
    end else if (out_valid && out_ready) begin
      retireCnt <= retireCnt + 64'd1;
    end
  end

  assign in_ready    = take[0];
  assign out_valid   = slotValid[STAGES-1] && !stall[STAGES-1];
  assign out_data    = slotData[STAGES-1];
  assign stage_valid = slotValid;
  assign retire_cnt  = retireCnt;

endmodule

// File: tb/tb_zc_pipe_chain.sv
// Self-checking bench for zc_pipe_chain: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a slot-array reference model.
module tb_zc_pipe_chain;
  import zc_pipe_chain_pkg::*;

  localparam int S   = 4;
  localparam int W   = 96;
  localparam int SDW = S * W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [S-1:0]   stall = '0;
  logic [S-1:0]   flush = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [S-1:0]   stage_valid;
  logic [SDW-1:0] stage_data;
  logic [63:0]    retire_cnt;

  zc_pipe_chain #(.STAGES(S), .DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: slot contents as plain arrays, advanced once per cycle.
  bit          mv [S];
  logic [W-1:0] md [S];
  logic [63:0] mRet;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [63:0] pcNext;
  logic [63:0] lastPc;
  int          scnCycle;
  int          firstValid;
  logic        lastInReady;

  task automatic check(input string tag, input logic [SDW-1:0] obs, input logic [SDW-1:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic doReset(input logic [S-1:0] st);
    @(negedge clk);
    #2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stall = st; flush = '0;
    #1;
    check("rst_stage_valid", stage_valid, '0);
    check("rst_stage_data", stage_data, '0);
    check("rst_retire_cnt", retire_cnt, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, !st[0]);
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mRet = '0;
    pcNext = 64'h8000_0000;
    lastPc = '0;
    firstValid = -1;
    scnCycle = 0;
    #1;
    rst = 1'b0; stall = '0;
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input bit iv, input bit ordy, input logic [S-1:0] st, input logic [S-1:0] fl);
    bit           tk [S+1];
    bit           nv [S];
    logic [W-1:0] nd [S];
    bit           src;
    bit           retire;
    logic [S-1:0] expSv;
    logic [SDW-1:0] expSd;
    bundle_t      b;
    @(negedge clk);
    b.pc = pcNext;
    b.inst = $urandom();
    in_valid = iv; out_ready = ordy; stall = st; flush = fl; in_data = b;
    #1;
    tk[S] = ordy;
    for (int i = S - 1; i >= 0; i--) tk[i] = !st[i] && (!mv[i] || tk[i+1]);
    for (int i = 0; i < S; i++) begin
      expSv[i] = mv[i];
      expSd[i*W +: W] = md[i];
    end
    retire = mv[S-1] && !st[S-1];
    check("in_ready", in_ready, tk[0]);
    check("out_valid", out_valid, retire);
    check("out_data", out_data, md[S-1]);
    check("stage_valid", stage_valid, expSv);
    check("stage_data", stage_data, expSd);
    check("retire_cnt", retire_cnt, mRet);
    lastInReady = in_ready;
    if (out_valid && firstValid < 0) firstValid = scnCycle;
    if (iv && tk[0]) pcNext += 64'd4;
    if (retire && ordy) begin
      check("order", out_data[W-1:32] > lastPc, 1'b1);
      lastPc = out_data[W-1:32];
      mRet++;
    end
    for (int i = 0; i < S; i++) begin
      nv[i] = mv[i];
      nd[i] = md[i];
      if (fl[i]) begin
        nv[i] = 1'b0;
      end else if (tk[i]) begin
        src = (i == 0) ? (iv && !fl[0]) : (mv[i-1] && !st[i-1] && !fl[i-1]);
        nv[i] = src;
        if (src) nd[i] = (i == 0) ? b : md[i-1];
      end
    end
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
    scnCycle++;
  endtask

  initial begin
    // Scenario 1: plain stream, latency and retire count.
    doReset('0);
    repeat (4) runCycle(1, 1, '0, '0);
    runCycle(0, 1, '0, '0);
    repeat (3) runCycle(0, 1, '0, '0);
    check("s1_latency", firstValid, 4);
    peek();
    check("s1_retire4", retire_cnt, 64'd4);

    // Scenario 2: downstream blocked fills the chain, then drains in order.
    doReset('0);
    repeat (4) runCycle(1, 0, '0, '0);
    runCycle(1, 0, '0, '0);
    check("s2_in_ready_full", lastInReady, 1'b0);
    repeat (8) runCycle(0, 1, '0, '0);
    peek();
    check("s2_retire4", retire_cnt, 64'd4);

    // Scenario 3: two-cycle stall of slot 1 inserts bubbles downstream.
    doReset('0);
    repeat (6) runCycle(1, 1, '0, '0);
    runCycle(1, 1, 4'b0010, '0);
    check("s3_in_ready_stall", lastInReady, 1'b0);
    peek();
    check("s3_bubble", stage_valid[2], 1'b0);
    runCycle(1, 1, 4'b0010, '0);
    repeat (8) runCycle(0, 1, '0, '0);

    // Scenario 4: flush the two youngest slots of a full chain.
    doReset('0);
    repeat (5) runCycle(1, 0, '0, '0);
    runCycle(0, 0, '0, 4'b0011);
    repeat (8) runCycle(0, 1, '0, '0);
    peek();
    check("s4_retire2", retire_cnt, 64'd2);

    // Scenario 5: stall and flush of slot 2 together.
    doReset('0);
    repeat (5) runCycle(1, 0, '0, '0);
    runCycle(0, 1, 4'b0100, 4'b0100);
    peek();
    check("s5_v2", stage_valid[2], 1'b0);
    check("s5_v3_bubble", stage_valid[3], 1'b0);
    repeat (6) runCycle(0, 1, '0, '0);
    peek();
    check("s5_retire3", retire_cnt, 64'd3);

    // Scenario 6: reset pulse mid-stream, then restart as scenario 1.
    repeat (3) runCycle(1, 1, '0, '0);
    doReset(4'b0001);
    repeat (4) runCycle(1, 1, '0, '0);
    repeat (4) runCycle(0, 1, '0, '0);
    check("s6_latency", firstValid, 4);
    peek();
    check("s6_retire4", retire_cnt, 64'd4);

    // Randomized traffic with occasional stalls and flushes.
    doReset('0);
    for (int n = 0; n < 600; n++) begin
      logic [S-1:0] st;
      logic [S-1:0] fl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(7) == 0);
        fl[i] = ($urandom_range(31) == 0);
      end
      runCycle($urandom_range(3) != 0, $urandom_range(3) != 0, st, fl);
    end
    repeat (8) runCycle(0, 1, '0, '0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
